// File: rtl/painterengine_gpu_reader_fifo.sv
// Reader-channel FIFO stage: buffers AXI read words and presents a counted valid/next stream.
// Optional head-word byte reversal via PAINTERENGINE_GPU_READER_FIFO_BYTE_SWAP_EN.
module painterengine_gpu_reader_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 4,
  parameter int LENGTH_WIDTH = 32
) (
  input  logic                    i_wire_clock,
  input  logic                    i_wire_reset,
  input  logic                    i_wire_start,
  input  logic [LENGTH_WIDTH-1:0] i_wire_length,
  output logic                    o_wire_busy,
  output logic                    o_wire_done,
  input  logic [DATA_WIDTH-1:0]   i_wire_in_data,
  input  logic                    i_wire_in_valid,
  output logic                    o_wire_in_next,
  output logic [DATA_WIDTH-1:0]   o_wire_out_data,
  output logic                    o_wire_out_valid,
  input  logic                    i_wire_out_next,
  output logic [DEPTH_LOG2:0]     o_wire_level
);

  // state   | meaning
  // ST_IDLE | no transfer armed since reset
  // ST_RUN  | words are being accepted and/or delivered
  // ST_DONE | last word consumed; waits for the next start
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int                      DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]     LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]     LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0]   PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [LENGTH_WIDTH-1:0] CNT_ONE    = LENGTH_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic [LENGTH_WIDTH-1:0] rx_count_q, rx_count_d;
  logic [LENGTH_WIDTH-1:0] tx_count_q, tx_count_d;
  logic [LENGTH_WIDTH-1:0] length_q, length_d;

  logic                    run;
  logic                    push;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   head_word;
  logic [DATA_WIDTH-1:0]   head_view;

  assign run = (state_q == ST_RUN);

  // Ready depends on registers only, so the reader never sees a valid->next loop.
  assign o_wire_in_next   = run && (level_q < LEVEL_FULL) && (rx_count_q < length_q);
  assign o_wire_out_valid = run && (level_q != '0);
  assign push             = i_wire_in_valid && o_wire_in_next;
  assign pop              = o_wire_out_valid && i_wire_out_next;

  assign o_wire_busy  = run;
  assign o_wire_done  = (state_q == ST_DONE);
  assign o_wire_level = level_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rx_count_d = rx_count_q;
    tx_count_d = tx_count_q;
    length_d   = length_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_wire_start) begin
          length_d   = i_wire_length;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          level_d    = '0;
          rx_count_d = '0;
          tx_count_d = '0;
          state_d    = (i_wire_length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (push) begin
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          rx_count_d = rx_count_q + CNT_ONE;
        end
        if (pop) begin
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          tx_count_d = tx_count_q + CNT_ONE;
          if ((tx_count_q + CNT_ONE) == length_q) begin
            state_d = ST_DONE;
          end
        end
        case ({push, pop})
          2'b10:   level_d = level_q + LEVEL_ONE;
          2'b01:   level_d = level_q - LEVEL_ONE;
          default: level_d = level_q;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rx_count_q <= '0;
      tx_count_q <= '0;
      length_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
      length_q   <= length_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_reset && push) begin
      mem_q[wr_ptr_q] <= i_wire_in_data;
    end
  end

  assign head_word = mem_q[rd_ptr_q];

`ifdef PAINTERENGINE_GPU_READER_FIFO_BYTE_SWAP_EN
  always_comb begin
    head_view = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      head_view[8*b +: 8] = head_word[DATA_WIDTH-8-8*b +: 8];
    end
  end
`else
  assign head_view = head_word;
`endif

  assign o_wire_out_data = o_wire_out_valid ? head_view : '0;

endmodule

// File: tb/tb_painterengine_gpu_reader_fifo.sv
// Randomized bench for painterengine_gpu_reader_fifo against a queue-based transfer model.
module tb_painterengine_gpu_reader_fifo;
  localparam int DW    = 32;
  localparam int DL    = 4;
  localparam int LW    = 32;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] length = '0;
  logic          busy, done;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_next;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_next = 1'b0;
  logic [DL:0]   level;
  logic [40:0]   dut_vec;

  int checks = 0;
  int errors = 0;

  int            m_state = M_IDLE;
  logic [DW-1:0] m_q[$];
  longint        m_len = 0, m_rx = 0, m_tx = 0;
  bit            last_push, last_pop;
  int            dut_push_total, dut_pop_total;

  always #5 clk = ~clk;

  painterengine_gpu_reader_fifo #(
    .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .LENGTH_WIDTH(LW)
  ) dut (
    .i_wire_clock(clk),
    .i_wire_reset(rst),
    .i_wire_start(start),
    .i_wire_length(length),
    .o_wire_busy(busy),
    .o_wire_done(done),
    .i_wire_in_data(in_data),
    .i_wire_in_valid(in_valid),
    .o_wire_in_next(in_next),
    .o_wire_out_data(out_data),
    .o_wire_out_valid(out_valid),
    .i_wire_out_next(out_next),
    .o_wire_level(level)
  );

  assign dut_vec = {busy, done, in_next, out_valid, level, out_data};

  function automatic logic [31:0] view(logic [31:0] w);
`ifdef PAINTERENGINE_GPU_READER_FIFO_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic bit exp_in_next();
    return (m_state == M_RUN) && (m_q.size() < DEPTH) && (m_rx < m_len);
  endfunction

  function automatic bit exp_valid();
    return (m_state == M_RUN) && (m_q.size() != 0);
  endfunction

  function automatic logic [40:0] exp_vec();
    logic [31:0] d;
    d = exp_valid() ? view(m_q[0]) : 32'h0;
    return {m_state == M_RUN, m_state == M_DONE, exp_in_next(), exp_valid(), 5'(m_q.size()), d};
  endfunction

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic tick();
    bit push, pop, dpush, dpop;
    logic [DW-1:0] junk;
    push  = in_valid && exp_in_next();
    pop   = exp_valid() && out_next;
    dpush = in_valid && in_next;
    dpop  = out_valid && out_next;
    @(posedge clk);
    #1;
    if (rst) begin
      m_state = M_IDLE; m_q.delete(); m_len = 0; m_rx = 0; m_tx = 0;
    end else begin
      if (dpush) dut_push_total++;
      if (dpop)  dut_pop_total++;
      if (start && m_state != M_RUN) begin
        m_len = length; m_rx = 0; m_tx = 0; m_q.delete();
        m_state = (length == 0) ? M_DONE : M_RUN;
      end else if (m_state == M_RUN) begin
        if (push) begin m_q.push_back(in_data); m_rx++; end
        if (pop) begin
          junk = m_q.pop_front();
          m_tx++;
          if (m_tx == m_len) m_state = M_DONE;
        end
      end
    end
    last_push = push;
    last_pop  = pop;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; length = '0; in_valid = 1'b0; out_next = 1'b0;
    tick(); tick();
    checks++;
    if (dut_vec !== 41'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 41'd0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic();
    logic [31:0] words[3];
    int idx = 0;
    int cyc = 0;
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    dut_push_total = 0; dut_pop_total = 0;
    start = 1'b1; length = 3; tick();
    in_valid = 1'b1; in_data = words[0]; out_next = 1'b1;
    while (m_state != M_DONE && cyc < 50) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL basic_cycle t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      tick(); cyc++;
      if (last_push) begin
        idx++;
        if (idx < 3) in_data = words[idx];
        else begin in_valid = 1'b0; in_data = '0; end
      end
    end
    checks++;
    if (done !== 1'b1 || in_next !== 1'b0 || dut_pop_total != 3) begin
      errors++; $display("FAIL basic_done done=%b in_next=%b pops=%0d exp done=1 in_next=0 pops=3", done, in_next, dut_pop_total);
    end
    in_valid = 1'b0; out_next = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    dut_push_total = 0; dut_pop_total = 0;
    start = 1'b1; length = 20; tick();
    in_valid = 1'b1; in_data = $urandom; out_next = 1'b0;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL bp_fill t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      tick();
      if (last_push) in_data = $urandom;
    end
    checks++;
    if (dut_push_total != 16 || level !== 5'd16 || in_next !== 1'b0) begin
      errors++; $display("FAIL bp_full pushes=%0d level=%0d in_next=%b exp 16/16/0", dut_push_total, level, in_next);
    end
    out_next = 1'b1;
    while (m_state != M_DONE && cyc < 100) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL bp_drain t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      tick(); cyc++;
      if (last_push) in_data = $urandom;
    end
    checks++;
    if (done !== 1'b1 || dut_push_total != 20 || dut_pop_total != 20) begin
      errors++; $display("FAIL bp_done done=%b pushes=%0d pops=%0d exp 1/20/20", done, dut_push_total, dut_pop_total);
    end
    in_valid = 1'b0; out_next = 1'b0;
  endtask

  task automatic test_full_pop();
    int cyc = 0;
    int push_before;
    start = 1'b1; length = 40; tick();
    in_valid = 1'b1; in_data = $urandom; out_next = 1'b0;
    while (m_q.size() < DEPTH && cyc < 30) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL full_fill t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      tick(); cyc++;
      if (last_push) in_data = $urandom;
    end
    checks++;
    if (level !== 5'd16 || in_next !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_state level=%0d in_next=%b valid=%b exp 16/0/1", level, in_next, out_valid);
    end
    out_next = 1'b1;
    push_before = dut_push_total;
    tick();
    if (last_push) in_data = $urandom;
    checks++;
    if (level !== 5'd15 || dut_push_total != push_before || in_next !== 1'b1) begin
      errors++; $display("FAIL full_pop level=%0d pushed=%0d in_next=%b exp 15/0/1", level, dut_push_total - push_before, in_next);
    end
    tick();
    if (last_push) in_data = $urandom;
    checks++;
    if (level !== 5'd15 || dut_push_total != push_before + 1) begin
      errors++; $display("FAIL full_resume level=%0d pushed=%0d exp 15/1", level, dut_push_total - push_before);
    end
    cyc = 0;
    while (m_state != M_DONE && cyc < 400) begin
      in_valid = 1'($urandom_range(0, 1));
      out_next = 1'($urandom_range(0, 1));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL full_drain t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      tick(); cyc++;
      if (last_push) in_data = $urandom;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL full_done done=%b exp=1", done);
    end
    in_valid = 1'b0; out_next = 1'b0;
  endtask

  task automatic test_zero_and_ignored_start();
    int cyc = 0;
    dut_push_total = 0; dut_pop_total = 0;
    in_valid = 1'b1; in_data = $urandom; out_next = 1'b1;
    start = 1'b1; length = 0; tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_next !== 1'b0) begin
      errors++; $display("FAIL zero_len done=%b busy=%b in_next=%b exp 1/0/0", done, busy, in_next);
    end
    tick();
    checks++;
    if (dut_vec !== exp_vec() || dut_push_total != 0) begin
      errors++; $display("FAIL zero_hold got=%h exp=%h pushes=%0d", dut_vec, exp_vec(), dut_push_total);
    end
    in_valid = 1'b0; out_next = 1'b0;
    start = 1'b1; length = 3; tick();
    in_valid = 1'b1; tick();
    if (last_push) in_data = $urandom;
    start = 1'b1; length = 5;
    while (m_state != M_DONE && cyc < 200) begin
      out_next = 1'($urandom_range(0, 1));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ign_start t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      tick(); cyc++;
      if (last_push) in_data = $urandom;
    end
    checks++;
    if (done !== 1'b1 || dut_push_total != 3 || dut_pop_total != 3) begin
      errors++; $display("FAIL ign_count done=%b pushes=%0d pops=%0d exp 1/3/3", done, dut_push_total, dut_pop_total);
    end
    in_valid = 1'b0; out_next = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    start = 1'b1; length = 8; tick();
    in_valid = 1'b1; in_data = $urandom; out_next = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (last_push) in_data = $urandom;
    end
    checks++;
    if (level !== 5'd4) begin
      errors++; $display("FAIL rstmid_level got=%0d exp=4", level);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (dut_vec !== 41'd0) begin
      errors++; $display("FAIL rstmid_flush got=%h exp=%h", dut_vec, 41'd0);
    end
    dut_push_total = 0; dut_pop_total = 0;
    start = 1'b1; length = 2; tick();
    while (m_state != M_DONE && cyc < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      out_next = 1'($urandom_range(0, 1));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rstmid_rerun t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
      end
      tick(); cyc++;
      if (last_push) in_data = $urandom;
    end
    checks++;
    if (done !== 1'b1 || dut_pop_total != 2) begin
      errors++; $display("FAIL rstmid_done done=%b pops=%0d exp 1/2", done, dut_pop_total);
    end
    in_valid = 1'b0; out_next = 1'b0;
  endtask

  task automatic test_byte_swap();
    logic [31:0] expected;
`ifdef PAINTERENGINE_GPU_READER_FIFO_BYTE_SWAP_EN
    expected = 32'hDDCCBBAA;
`else
    expected = 32'hAABBCCDD;
`endif
    start = 1'b1; length = 1; tick();
    in_valid = 1'b1; in_data = 32'hAABBCCDD; out_next = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== expected || out_valid !== 1'b1) begin
      errors++; $display("FAIL byte_swap data=%h valid=%b exp data=%h valid=1", out_data, out_valid, expected);
    end
    out_next = 1'b1; tick(); out_next = 1'b0;
    checks++;
    if (done !== 1'b1 || out_data !== 32'h0) begin
      errors++; $display("FAIL byte_swap_done done=%b data=%h exp 1/0", done, out_data);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      int cyc = 0;
      int len = $urandom_range(1, 40);
      dut_pop_total = 0;
      start = 1'b1; length = len; tick();
      while (m_state != M_DONE && cyc < 600) begin
        in_valid = 1'($urandom_range(0, 1));
        out_next = 1'($urandom_range(0, 3) != 0);
        if (in_valid && $urandom_range(0, 1) == 1) in_data = $urandom;
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL random_cycle t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
        end
        tick(); cyc++;
      end
      checks++;
      if (done !== 1'b1 || dut_pop_total != len) begin
        errors++; $display("FAIL random_done done=%b pops=%0d exp 1/%0d", done, dut_pop_total, len);
      end
      in_valid = 1'b0; out_next = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_full_pop();
    test_zero_and_ignored_start();
    test_reset_mid();
    test_byte_swap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_reader_fifo.md
Name: painterengine_gpu_reader_fifo

Overview:
- Downstream stage of the GPU DMA reader. Attaches to one router channel of the reader: its data, its valid, and the per-channel next/ready line.
- Buffers the AXI read-burst words in a first-word-fall-through FIFO.
- Enforces the word count of the transfer and presents a clean valid/next stream to the pixel consumer (sampler or blender).
- Decouples consumer stalls from the AXI R channel and reports done when the last word has been consumed.

Parameters:
- DATA_WIDTH, 32, width of one word; matches the AXI RDATA width.
- DEPTH_LOG2, 4, log2 of the FIFO depth; default depth is 16 words.
- LENGTH_WIDTH, 32, width of the word-count input and the internal counters.

Ports:
- i_wire_clock, in, 1: the single clock. All logic is on its rising edge.
- i_wire_reset, in, 1: synchronous, active-high reset.
- i_wire_start, in, 1: one-cycle pulse that arms a transfer. Sampled only in IDLE or DONE.
- i_wire_length, in, LENGTH_WIDTH: number of 32-bit words to transfer. Latched on start.
- o_wire_busy, out, 1: high in the RUN state.
- o_wire_done, out, 1: high in the DONE state.
- i_wire_in_data, in, DATA_WIDTH: word from the reader channel.
- i_wire_in_valid, in, 1: reader channel valid.
- o_wire_in_next, out, 1: ready to the reader; drives the reader's data_next bit.
- o_wire_out_data, out, DATA_WIDTH: FIFO head word.
- o_wire_out_valid, out, 1: FIFO not empty while in RUN.
- i_wire_out_next, in, 1: consumer ready.
- o_wire_level, out, DEPTH_LOG2+1: current FIFO occupancy.

Behaviour:
- Reset: state=IDLE; pointers, level, rx_count, tx_count and the latched length all 0. Outputs after reset: o_wire_in_next=0, o_wire_out_valid=0, o_wire_out_data=0, busy=0, done=0, level=0.
- Reset mid-transfer flushes all buffered words with no further handshakes.
- States:
  - IDLE: on start, go to RUN with length≠0 latched; go directly to DONE if length=0.
  - RUN: transfer in progress.
  - DONE: holds until the next start, then re-arms exactly as from IDLE; rx_count, tx_count and the pointers are cleared.
  - A start pulse during RUN is ignored.
- Push handshake: a push occurs when i_wire_in_valid && o_wire_in_next.
  - o_wire_in_next = (state==RUN) && (level<2^DEPTH_LOG2) && (rx_count<length). It is combinational from registers only and independent of i_wire_in_valid.
  - A full FIFO refuses a push even if a pop happens in the same cycle.
- Pop handshake: a pop occurs when o_wire_out_valid && i_wire_out_next.
  - o_wire_out_valid = (state==RUN) && (level≠0).
  - o_wire_out_data = mem[rd_ptr] when valid; it is 0 when not valid.
- Latency: a word pushed at edge N is valid on the output after edge N, i.e. one cycle.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- Pointers are DEPTH_LOG2 bits and wrap modulo the depth.
- Counters: rx_count increments on each push, tx_count on each pop. Neither ever exceeds length.
- Transition RUN→DONE at the edge where the pop makes tx_count reach length. done rises on the following cycle.
- Level wrap: level never exceeds 2^DEPTH_LOG2 and never underflows. A pop with level=0 is impossible because valid=0.
- in_valid while next=0 is ignored, with no error; the upstream reader holds its data per the AXI rules.

Optional Feature:
- Macro: PAINTERENGINE_GPU_READER_FIFO_BYTE_SWAP_EN.
- When defined, o_wire_out_data presents the head word byte-reversed: {b0,b1,b2,b3}, converting big-endian ARGB memory into the GPU's little-endian pixel order. The swap is combinational on the read path; FIFO contents, latency and handshakes are unchanged.
- When undefined, the head word is passed through unmodified.

Test Plan:
- Basic transfer: reset, start with length=3, input 0x11111111/0x22222222/0x33333333 back-to-back, out_next=1 → outputs appear in order, each 1 cycle after its push; done=1 after the third pop; in_next=0 after the third push.
- Backpressure: DEPTH_LOG2=4, length=20, in_valid=1 constant, out_next=0 → exactly 16 pushes, level=16, in_next=0. Then out_next=1 → the remaining 4 words flow, done after 20 pops, no loss or duplication.
- Full with simultaneous pop: level=16, in_valid=1, out_next=1 → pop occurs, no push that cycle, level=15; push resumes next cycle.
- Zero length and ignored start: start with length=0 → DONE one cycle later, in_next never asserted. A start pulse during RUN with length=5 → the active length of 3 is unaffected.
- Reset mid-transfer: length=8, 4 words buffered, assert i_wire_reset one cycle → level=0, valid=0, in_next=0, state IDLE. A new start with length=2 completes normally.
- Byte swap (macro defined): push 0xAABBCCDD → o_wire_out_data=0xDDCCBBAA. With the macro undefined → 0xAABBCCDD.
